// File: rtl/munoc_flit_arbiter.sv
// munoc_flit_arbiter
// Merges NUM_REQ flit sources onto one link with round-robin priority.
// A packet, once offered, keeps the link until its tail flit is accepted,
// so packets are never interleaved. The arbiter holds no flit storage:
// the link is driven straight from the granted source with zero latency.

module munoc_flit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int BW_FLIT = 8
) (
   input  logic                       clk,
   input  logic                       rstnn,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [NUM_REQ*BW_FLIT-1:0] req_flit,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic                       out_last,
   output logic [BW_FLIT-1:0]         out_flit,
   input  logic                       out_ready,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   ptr_q;     // last source whose tail flit was accepted
   logic [IDX_W-1:0]   lidx_q;    // source that owns the link while locked

   logic [IDX_W-1:0]   sel_idx;
   logic               sel_any;
   logic               handshake;

   // Pick the source that drives the link: the lock owner, or the first valid
   // source after ptr_q in round-robin order.
   always_comb begin
      logic [IDX_W-1:0] cand_idx;
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cand_idx = '0;
      sel_any  = 1'b0;
      sel_idx  = lidx_q;
      if (state_q == ST_LOCKED) begin
         sel_any = 1'b1;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!sel_any && req_valid[cand_idx]) begin
               sel_any = 1'b1;
               sel_idx = cand_idx;
            end
         end
      end
   end

   // Route the granted source onto the link and return its ready.
   always_comb begin
      grant     = '0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_flit  = '0;
      if (sel_any) begin
         grant[sel_idx] = 1'b1;
         out_valid      = req_valid[sel_idx];
         out_last       = req_last[sel_idx];
         out_flit       = req_flit[int'(sel_idx)*BW_FLIT +: BW_FLIT];
      end
      req_ready = grant & {NUM_REQ{out_ready}};
   end

   assign handshake = out_valid & out_ready;
   assign busy      = (state_q == ST_LOCKED);

   // Lock / release FSM together with the round-robin pointer and lock index.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q <= ST_IDLE;
         ptr_q   <= IDX_W'(NUM_REQ - 1);
         lidx_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         case (state_q)
            ST_IDLE: begin
               if (handshake && out_last) begin
                  ptr_q <= sel_idx;
               end else if (out_valid) begin
                  // An offered flit must not be withdrawn or switched.
                  state_q <= ST_LOCKED;
                  lidx_q  <= sel_idx;
               end
            end
            ST_LOCKED: begin
               if (handshake && out_last) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= lidx_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_munoc_flit_arbiter.sv
// Bench for munoc_flit_arbiter: directed scenarios followed by random
// traffic, all compared against a packet-level reference model.

module tb_munoc_flit_arbiter;

   localparam int N  = 4;
   localparam int BW = 8;

   logic            clk = 1'b0;
   logic            rstnn;
   logic [N-1:0]    v;
   logic [N-1:0]    l;
   logic [N*BW-1:0] flits;
   logic            rdy;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic            out_last;
   logic [BW-1:0]   out_flit;
   logic [N-1:0]    grant;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: owner of the packet in flight (-1 when none) and the
   // source whose packet ended most recently.
   int m_owner;
   int m_last;

   munoc_flit_arbiter #(.NUM_REQ(N), .BW_FLIT(BW)) dut (
      .clk       (clk),
      .rstnn     (rstnn),
      .req_valid (v),
      .req_last  (l),
      .req_flit  (flits),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_flit  (out_flit),
      .out_ready (rdy),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic int exp_idx();
      if (m_owner >= 0) return m_owner;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic check_all(input string tag);
      int               g;
      logic [N-1:0]     e_grant;
      logic             e_valid;
      logic             e_last;
      logic [BW-1:0]    e_flit;
      g       = exp_idx();
      e_grant = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_flit  = '0;
      if (g >= 0) begin
         e_grant[g] = 1'b1;
         e_valid    = v[g];
         e_last     = l[g];
         e_flit     = flits[g*BW +: BW];
      end
      chk({tag, ".grant"},     32'(grant),     32'(e_grant));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
      chk({tag, ".out_last"},  32'(out_last),  32'(e_last));
      chk({tag, ".out_flit"},  32'(out_flit),  32'(e_flit));
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(e_grant & {N{rdy}}));
      chk({tag, ".busy"},      32'(busy),      32'(m_owner >= 0));
   endtask

   // Advance one clock, updating the model from what the link should have
   // carried this cycle; returns at the following falling edge.
   task automatic tick();
      int   g;
      logic ev;
      logic el;
      g  = exp_idx();
      ev = (g >= 0) ? v[g] : 1'b0;
      el = (g >= 0) ? l[g] : 1'b0;
      @(posedge clk);
      if (rstnn && g >= 0) begin
         if (ev && rdy && el) begin
            m_last  = g;
            m_owner = -1;
         end else if (m_owner >= 0 || ev) begin
            m_owner = g;
         end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
   endtask

   initial begin
      // Reset state
      rstnn = 1'b0;
      v = '0; l = '0; flits = '0; rdy = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rstnn = 1'b1;

      // Round robin, back-to-back single-flit packets from every source
      v = 4'b1111; l = 4'b1111; rdy = 1'b1;
      flits = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      for (int i = 0; i < N; i++) begin
         logic [7:0] pay;
         #1;
         pay = flits[i*BW +: BW];
         check_all("rr");
         chk("rr.seq_grant", 32'(grant), 32'(1 << i));
         chk("rr.seq_flit",  32'(out_flit), 32'(pay));
         tick();
      end

      // Move the pointer to source 1, then source 2 sends a 3-flit packet
      // while source 0 stays valid.
      v = 4'b0010; l = 4'b0010; flits = 32'h0000_1100;
      #1; check_all("prep1"); tick();
      v = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         l = (i == 2) ? 4'b0101 : 4'b0001;
         flits = {8'h00, 8'(8'h20 + i), 8'h00, 8'h0A};
         #1;
         check_all("pkt3");
         chk("pkt3.grant", 32'(grant), 32'h4);
         chk("pkt3.busy",  32'(busy), 32'(i > 0));
         tick();
      end
      #1; check_all("pkt3.after");
      chk("pkt3.after_grant", 32'(grant), 32'h1);
      tick();

      // Source 1 stalled by downstream; source 0 joins later
      v = 4'b0010; l = 4'b0010; rdy = 1'b0; flits = 32'h0000_5500;
      for (int i = 0; i < 7; i++) begin
         if (i == 5) v = 4'b0011;
         #1;
         check_all("stall");
         chk("stall.grant", 32'(grant), 32'h2);
         chk("stall.flit",  32'(out_flit), 32'h55);
         chk("stall.ready", 32'(req_ready), 32'h0);
         tick();
      end
      rdy = 1'b1;
      #1; check_all("stall.release");
      chk("stall.release_ready", 32'(req_ready), 32'h2);
      tick();

      // Lock on source 3, its valid drops for two cycles mid-packet
      v = 4'b1000; l = 4'b0000; flits = 32'h7700_0000;
      #1; check_all("gap.first"); tick();
      v = 4'b0010; l = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_all("gap");
         chk("gap.valid", 32'(out_valid), 32'h0);
         chk("gap.grant", 32'(grant), 32'h8);
         chk("gap.ready1", 32'(req_ready[1]), 32'h0);
         tick();
      end
      v = 4'b1010; l = 4'b1010;
      #1; check_all("gap.tail"); tick();

      // Pointer now at source 3: wrap-around to source 0
      v = 4'b1001; l = 4'b1001; flits = 32'h3300_0001;
      #1; check_all("wrap");
      chk("wrap.grant", 32'(grant), 32'h1);
      tick();

      // Reset asserted while locked on source 2
      v = 4'b0100; l = 4'b0000; flits = 32'h0044_0000;
      #1; check_all("rst.lock"); tick();
      chk("rst.locked_busy", 32'(busy), 32'h1);
      #2; rstnn = 1'b0; model_reset();
      v = 4'b0101; l = 4'b0101;
      #1;
      chk("rst.busy_now", 32'(busy), 32'h0);
      check_all("rst.during");
      @(negedge clk);
      rstnn = 1'b1;
      #1;
      check_all("rst.after");
      chk("rst.after_grant", 32'(grant), 32'h1);
      tick();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         v     = 4'($urandom);
         l     = 4'($urandom);
         rdy   = ($urandom_range(0, 3) != 0);
         flits = $urandom;
         #1;
         check_all("rand");
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
